sample_delay_aligner: RTL and testbench
=======================================

# sample_delay_aligner

Parametrised, valid-counted sample delay line that aligns the raw input stream with a late-arriving sync event, such as a PSS peak detected after the decimator and correlator pipeline. It delays by a number of valid samples, not clock cycles, so the alignment is independent of input duty cycle. The delay is programmable at run time. A one-bit sync tag travels with each sample and reappears on `m_axis_out_tuser`. It sits between the receiver input and FFT_demod, replacing a fixed-length shift register.

## Interface
- `IN_DW`, 32: sample width (I/Q packed).
- `MAX_DELAY`, 64: ring depth and largest supported delay, in samples; must be a power of two, ≥ 2.
- `DEFAULT_DELAY`, 16: delay in force after reset; 1 ≤ `DEFAULT_DELAY` ≤ `MAX_DELAY`.
- `DELAY_W`, `$clog2(MAX_DELAY)+1`: width of `delay_i`.

Ports:
- `clk_i`  in  1  single clock; everything is on its rising edge.
- `reset_ni`  in  1  reset, asynchronous and active-low.
- `s_axis_in_tdata`  in  `IN_DW`  input sample.
- `s_axis_in_tvalid`  in  1  input sample valid; there is no backpressure.
- `sync_i`  in  1  sync tag for the current input sample; ignored unless `s_axis_in_tvalid`=1.
- `delay_i`  in  `DELAY_W`  requested delay in samples; loaded only on `flush_i`.
- `flush_i`  in  1  discard buffer contents, load `delay_i`, restart fill.
- `m_axis_out_tdata`  out  `IN_DW`  delayed sample.
- `m_axis_out_tvalid`  out  1  delayed sample valid.
- `m_axis_out_tuser`  out  1  sync tag belonging to the delayed sample.
- `primed_o`  out  1  fill complete; valid samples now flow through.
- `sync_dropped_o`  out  1  one-cycle pulse: a flush discarded ≥1 in-flight sync tag.

## Operation
- **Storage.** Ring buffer of `MAX_DELAY` entries, each {tag, data}, plus write pointer `wp` (`$clog2(MAX_DELAY)` bits, wraps naturally).
- **Active delay `D`.**
  - Reset value is `DEFAULT_DELAY`.
  - On `flush_i`, `D` is loaded from `delay_i`, clamped: 0 → 1, > `MAX_DELAY` → `MAX_DELAY`.
- **Per accepted input** (`s_axis_in_tvalid`=1, `flush_i`=0):
  - read entry at `wp − D` (mod `MAX_DELAY`), reading the old content before the write;
  - write {`sync_i`, `s_axis_in_tdata`} at `wp`;
  - advance `wp` by 1.
- **Fill counter `fill`** (0..`D`):
  - increments on each accepted input while `fill` < `D`;
  - `primed_o` = (`fill` == `D`).
- **Output.** Produced only for an accepted input that arrives while already primed. The output sample is the one accepted exactly `D` valid samples earlier.
  - Sample n is output when sample n+D is accepted.
  - `D` = `MAX_DELAY` is legal: the read hits `wp` itself and returns the old content.
- **In-flight tag counter `tags`** (0..`MAX_DELAY`):
  - +1 when a tagged sample is written;
  - −1 when a tagged sample is output;
  - both in the same cycle: unchanged.
- **Flush** (priority over input):
  - `fill`, `tags` and `wp` are cleared, and `D` is loaded;
  - `sync_dropped_o` pulses next cycle if `tags` > 0, or if the same-cycle input is tagged;
  - a same-cycle input sample is discarded;
  - no output is produced in the flush cycle.
- **Reset.** Asynchronous assertion clears all state immediately. Ring contents need not be reset; they are unreadable until refilled.

## Timing
- **Reset values.** Outputs: `m_axis_out_tdata`=0, `m_axis_out_tvalid`=0, `m_axis_out_tuser`=0, `primed_o`=0, `sync_dropped_o`=0. Internal: `wp`=0, `fill`=0, `tags`=0, `D`=`DEFAULT_DELAY`.
- **Latency.** Accepted input at edge t → output registered at edge t+1. `m_axis_out_tvalid` is high for exactly one cycle per output.
- **Hold.** `m_axis_out_tdata` and `m_axis_out_tuser` hold their last value while `tvalid`=0. `tuser` is meaningful only with `tvalid`.
- **`primed_o` timing.** Rises at the edge where `fill` reaches `D`. The first output accompanies the next accepted input.
- **Idle gaps.** Gaps in `s_axis_in_tvalid` do not change the sample-count delay; only the cycle latency stretches.
- **Back-to-back.** Input valid every cycle gives output valid every cycle once primed.
- **Reset mid-stream.** Outputs drop to reset values asynchronously. No output is produced for samples accepted before reset.

## Test plan
- **Default delay, continuous stream.**
  - Stimulus: reset, then samples 1..40 valid every cycle.
  - Response: `primed_o` rises after sample 16; output sample 1 appears one cycle after input 17; outputs 1..24 are contiguous and in order.
- **Gapped input.**
  - Stimulus: `D`=16, valid every third cycle.
  - Response: output n accompanies input n+16 (one edge later), independent of the gaps.
- **Sync tag.**
  - Stimulus: `sync_i`=1 on sample 5 only, `D`=10.
  - Response: `m_axis_out_tuser`=1 only with output sample 5, one cycle after input 15.
- **Flush with new delay.**
  - Stimulus: `flush_i` with `delay_i`=64 (MAX).
  - Response: `primed_o` falls; next 64 inputs produce no output; input 65 yields output 1.
- **Clamp cases.**
  - `delay_i`=0 acts as 1: each output equals the previous input.
  - `delay_i`=100 acts as 64.
- **Dropped sync.**
  - Stimulus: tagged sample in flight, then `flush_i`.
  - Response: `sync_dropped_o` pulses once; no tag appears later.
  - Also: flush coincident with a tagged input pulses it; a flush with no tags in flight does not.

Source files
------------

// File: rtl/sample_delay_aligner.sv
// Valid-counted sample delay line: each sample (with its one-bit sync tag) is
// re-emitted when the D-th following valid sample is accepted.
module sample_delay_aligner #(
    parameter int unsigned IN_DW         = 32,
    parameter int unsigned MAX_DELAY     = 64,
    parameter int unsigned DEFAULT_DELAY = 16,
    parameter int unsigned DELAY_W       = $clog2(MAX_DELAY) + 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [IN_DW-1:0]   s_axis_in_tdata,
    input  logic               s_axis_in_tvalid,
    input  logic               sync_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic               flush_i,
    output logic [IN_DW-1:0]   m_axis_out_tdata,
    output logic               m_axis_out_tvalid,
    output logic               m_axis_out_tuser,
    output logic               primed_o,
    output logic               sync_dropped_o
);

    localparam int unsigned AW = $clog2(MAX_DELAY);

    typedef logic [IN_DW:0] entry_t;

    entry_t             ring_q [MAX_DELAY];
    logic [AW-1:0]      wp_q, wp_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic [DELAY_W-1:0] fill_q, fill_d;
    logic [DELAY_W-1:0] tags_q, tags_d;
    logic [IN_DW-1:0]   tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tuser_q, tuser_d;
    logic               dropped_q, dropped_d;

    logic               accept;
    logic               primed;
    logic               fire;
    logic [AW-1:0]      rd_addr;
    entry_t             rd_entry;
    logic [DELAY_W-1:0] delay_clamped;

    assign accept   = s_axis_in_tvalid && !flush_i;
    assign primed   = (fill_q == dly_q);
    assign fire     = accept && primed;
    // D == MAX_DELAY wraps onto wp itself; the read still sees the old entry.
    assign rd_addr  = wp_q - dly_q[AW-1:0];
    assign rd_entry = ring_q[rd_addr];

    always_comb begin
        delay_clamped = delay_i;
        if (delay_i == '0) begin
            delay_clamped = DELAY_W'(1);
        end else if (delay_i > DELAY_W'(MAX_DELAY)) begin
            delay_clamped = DELAY_W'(MAX_DELAY);
        end
    end

    always_comb begin
        wp_d      = wp_q;
        dly_d     = dly_q;
        fill_d    = fill_q;
        tags_d    = tags_q;
        tdata_d   = tdata_q;
        tvalid_d  = 1'b0;
        tuser_d   = tuser_q;
        dropped_d = 1'b0;
        if (flush_i) begin
            wp_d      = '0;
            dly_d     = delay_clamped;
            fill_d    = '0;
            tags_d    = '0;
            dropped_d = (tags_q != '0) || (s_axis_in_tvalid && sync_i);
        end else if (accept) begin
            wp_d = wp_q + AW'(1);
            if (!primed) begin
                fill_d = fill_q + DELAY_W'(1);
            end
            if (fire) begin
                tvalid_d = 1'b1;
                tdata_d  = rd_entry[IN_DW-1:0];
                tuser_d  = rd_entry[IN_DW];
            end
            // Net in-flight tag count: a tag entering and one leaving cancel.
            case ({sync_i, fire && rd_entry[IN_DW]})
                2'b10:   tags_d = tags_q + DELAY_W'(1);
                2'b01:   tags_d = tags_q - DELAY_W'(1);
                default: tags_d = tags_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wp_q      <= '0;
            dly_q     <= DELAY_W'(DEFAULT_DELAY);
            fill_q    <= '0;
            tags_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tuser_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            dly_q     <= dly_d;
            fill_q    <= fill_d;
            tags_q    <= tags_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tuser_q   <= tuser_d;
            dropped_q <= dropped_d;
        end
    end

    // Ring contents are never reset; fill gating keeps stale entries unread.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            ring_q[wp_q] <= {sync_i, s_axis_in_tdata};
        end
    end

    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign m_axis_out_tuser  = tuser_q;
    assign primed_o          = primed;
    assign sync_dropped_o    = dropped_q;

endmodule

// File: tb/tb_sample_delay_aligner.sv
// Directed, self-checking bench for sample_delay_aligner with default parameters.
module tb_sample_delay_aligner;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] s_axis_in_tdata;
    logic        s_axis_in_tvalid;
    logic        sync_i;
    logic [6:0]  delay_i;
    logic        flush_i;
    logic [31:0] m_axis_out_tdata;
    logic        m_axis_out_tvalid;
    logic        m_axis_out_tuser;
    logic        primed_o;
    logic        sync_dropped_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    sample_delay_aligner dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .sync_i            (sync_i),
        .delay_i           (delay_i),
        .flush_i           (flush_i),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .m_axis_out_tuser  (m_axis_out_tuser),
        .primed_o          (primed_o),
        .sync_dropped_o    (sync_dropped_o)
    );

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [31:0] d, input logic s,
                        input logic f, input logic [6:0] dl);
        s_axis_in_tvalid = v;
        s_axis_in_tdata  = d;
        sync_i           = s;
        flush_i          = f;
        delay_i          = dl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        s_axis_in_tvalid = 1'b0; s_axis_in_tdata = '0; sync_i = 1'b0;
        flush_i = 1'b0; delay_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (m_axis_out_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_axis_out_tdata); end
        checks++; if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_out_tvalid); end
        checks++; if (m_axis_out_tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser got=%b exp=0", m_axis_out_tuser); end
        checks++; if (primed_o !== 1'b0) begin failures++; $display("FAIL reset_primed got=%b exp=0", primed_o); end
        checks++; if (sync_dropped_o !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", sync_dropped_o); end
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_default_stream();
        logic [31:0] base = 32'hA100_0000;
        for (int n = 1; n <= 40; n++) begin
            step(1'b1, base + 32'(n), 1'b0, 1'b0, '0);
            checks++; if (primed_o !== 1'(n >= 16)) begin failures++; $display("FAIL stream_primed n=%0d got=%b exp=%b", n, primed_o, n >= 16); end
            checks++; if (m_axis_out_tvalid !== 1'(n >= 17)) begin failures++; $display("FAIL stream_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 17); end
            if (n >= 17) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 16)) begin failures++; $display("FAIL stream_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 16)); end
                checks++; if (m_axis_out_tuser !== 1'b0) begin failures++; $display("FAIL stream_tuser n=%0d got=%b exp=0", n, m_axis_out_tuser); end
            end
        end
        $display("test_default_stream done");
    endtask

    task automatic test_gapped();
        logic [31:0] base = 32'hA200_0000;
        step(1'b0, '0, 1'b0, 1'b1, 7'd16);
        checks++; if (primed_o !== 1'b0) begin failures++; $display("FAIL gap_flush_primed got=%b exp=0", primed_o); end
        checks++; if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL gap_flush_tvalid got=%b exp=0", m_axis_out_tvalid); end
        for (int n = 1; n <= 30; n++) begin
            step(1'b1, base + 32'(n), 1'b0, 1'b0, '0);
            checks++; if (m_axis_out_tvalid !== 1'(n >= 17)) begin failures++; $display("FAIL gap_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 17); end
            if (n >= 17) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 16)) begin failures++; $display("FAIL gap_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 16)); end
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
                checks++; if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL gap_idle_tvalid n=%0d got=%b exp=0", n, m_axis_out_tvalid); end
                if (n >= 17) begin
                    checks++; if (m_axis_out_tdata !== base + 32'(n - 16)) begin failures++; $display("FAIL gap_hold n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 16)); end
                end
            end
        end
        $display("test_gapped done");
    endtask

    task automatic test_sync_tag();
        logic [31:0] base = 32'hA300_0000;
        step(1'b0, '0, 1'b0, 1'b1, 7'd10);
        for (int n = 1; n <= 25; n++) begin
            step(1'b1, base + 32'(n), 1'(n == 5), 1'b0, '0);
            checks++; if (m_axis_out_tvalid !== 1'(n >= 11)) begin failures++; $display("FAIL sync_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 11); end
            if (n >= 11) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 10)) begin failures++; $display("FAIL sync_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 10)); end
                checks++; if (m_axis_out_tuser !== 1'(n == 15)) begin failures++; $display("FAIL sync_tuser n=%0d got=%b exp=%b", n, m_axis_out_tuser, n == 15); end
            end
        end
        $display("test_sync_tag done");
    endtask

    task automatic test_flush_max();
        logic [31:0] base = 32'hA400_0000;
        checks++; if (primed_o !== 1'b1) begin failures++; $display("FAIL max_pre_primed got=%b exp=1", primed_o); end
        step(1'b0, '0, 1'b0, 1'b1, 7'd64);
        checks++; if (primed_o !== 1'b0) begin failures++; $display("FAIL max_flush_primed got=%b exp=0", primed_o); end
        checks++; if (sync_dropped_o !== 1'b0) begin failures++; $display("FAIL max_no_drop got=%b exp=0", sync_dropped_o); end
        for (int n = 1; n <= 70; n++) begin
            step(1'b1, base + 32'(n), 1'b0, 1'b0, '0);
            checks++; if (m_axis_out_tvalid !== 1'(n >= 65)) begin failures++; $display("FAIL max_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 65); end
            checks++; if (primed_o !== 1'(n >= 64)) begin failures++; $display("FAIL max_primed n=%0d got=%b exp=%b", n, primed_o, n >= 64); end
            if (n >= 65) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 64)) begin failures++; $display("FAIL max_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 64)); end
            end
        end
        $display("test_flush_max done");
    endtask

    task automatic test_clamp();
        logic [31:0] base = 32'hA500_0000;
        step(1'b0, '0, 1'b0, 1'b1, 7'd0);
        for (int n = 1; n <= 6; n++) begin
            step(1'b1, base + 32'(n), 1'b0, 1'b0, '0);
            checks++; if (primed_o !== 1'b1) begin failures++; $display("FAIL clamp0_primed n=%0d got=%b exp=1", n, primed_o); end
            checks++; if (m_axis_out_tvalid !== 1'(n >= 2)) begin failures++; $display("FAIL clamp0_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 2); end
            if (n >= 2) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 1)) begin failures++; $display("FAIL clamp0_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 1)); end
            end
        end
        base = 32'hA600_0000;
        step(1'b0, '0, 1'b0, 1'b1, 7'd100);
        for (int n = 1; n <= 66; n++) begin
            step(1'b1, base + 32'(n), 1'b0, 1'b0, '0);
            checks++; if (m_axis_out_tvalid !== 1'(n >= 65)) begin failures++; $display("FAIL clamp100_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 65); end
            if (n >= 65) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 64)) begin failures++; $display("FAIL clamp100_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 64)); end
            end
        end
        $display("test_clamp done");
    endtask

    task automatic test_dropped_sync();
        logic [31:0] base = 32'hA700_0000;
        step(1'b0, '0, 1'b0, 1'b1, 7'd8);
        checks++; if (sync_dropped_o !== 1'b0) begin failures++; $display("FAIL drop_clean_flush got=%b exp=0", sync_dropped_o); end
        for (int n = 1; n <= 3; n++) step(1'b1, base + 32'(n), 1'(n == 2), 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 7'd8);
        checks++; if (sync_dropped_o !== 1'b1) begin failures++; $display("FAIL drop_inflight got=%b exp=1", sync_dropped_o); end
        step(1'b0, '0, 1'b0, 1'b0, '0);
        checks++; if (sync_dropped_o !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%b exp=0", sync_dropped_o); end
        step(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 7'd8);
        checks++; if (sync_dropped_o !== 1'b1) begin failures++; $display("FAIL drop_coincident got=%b exp=1", sync_dropped_o); end
        checks++; if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL drop_flush_tvalid got=%b exp=0", m_axis_out_tvalid); end
        step(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 7'd8);
        checks++; if (sync_dropped_o !== 1'b0) begin failures++; $display("FAIL drop_untagged_flush got=%b exp=0", sync_dropped_o); end
        for (int n = 1; n <= 10; n++) begin
            step(1'b1, base + 32'(16 + n), 1'b0, 1'b0, '0);
            checks++; if (m_axis_out_tvalid !== 1'(n >= 9)) begin failures++; $display("FAIL drop_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 9); end
            if (n >= 9) begin
                checks++; if (m_axis_out_tdata !== base + 32'(16 + n - 8)) begin failures++; $display("FAIL drop_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(16 + n - 8)); end
                checks++; if (m_axis_out_tuser !== 1'b0) begin failures++; $display("FAIL drop_tuser n=%0d got=%b exp=0", n, m_axis_out_tuser); end
            end
        end
        $display("test_dropped_sync done");
    endtask

    task automatic test_reset_midstream();
        logic [31:0] base = 32'hA800_0000;
        step(1'b1, base, 1'b0, 1'b0, '0);
        checks++; if (m_axis_out_tvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_tvalid got=%b exp=1", m_axis_out_tvalid); end
        #2;
        reset_ni = 1'b0;
        #1;
        checks++; if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL mid_async_tvalid got=%b exp=0", m_axis_out_tvalid); end
        checks++; if (m_axis_out_tdata !== 32'h0) begin failures++; $display("FAIL mid_async_tdata got=%h exp=0", m_axis_out_tdata); end
        checks++; if (primed_o !== 1'b0) begin failures++; $display("FAIL mid_async_primed got=%b exp=0", primed_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step(1'b1, base + 32'(n), 1'b0, 1'b0, '0);
            checks++; if (m_axis_out_tvalid !== 1'(n >= 17)) begin failures++; $display("FAIL mid_tvalid n=%0d got=%b exp=%b", n, m_axis_out_tvalid, n >= 17); end
            if (n >= 17) begin
                checks++; if (m_axis_out_tdata !== base + 32'(n - 16)) begin failures++; $display("FAIL mid_tdata n=%0d got=%h exp=%h", n, m_axis_out_tdata, base + 32'(n - 16)); end
            end
        end
        $display("test_reset_midstream done");
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_gapped();
        test_sync_tag();
        test_flush_max();
        test_clamp();
        test_dropped_sync();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
